// File: rtl/l1_dcache_sa_if.sv
// CPU request/response and memory read/write channels of l1_dcache_sa.
// The cache is the slave; the CPU and memory side together form the master.
interface l1_dcache_sa_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CPU_WIDTH  = 32,
  parameter int LINE_WIDTH = 128
);
  logic                      cpu_req_valid;
  logic                      cpu_req_ready;
  logic [ADDR_WIDTH-1:0]     cpu_req_addr;
  logic                      cpu_req_write;
  logic [CPU_WIDTH-1:0]      cpu_req_wdata;
  logic [CPU_WIDTH/8-1:0]    cpu_req_wmask;

  logic                      cpu_resp_valid;
  logic [CPU_WIDTH-1:0]      cpu_resp_rdata;
  logic                      cpu_resp_hit;
  logic                      cpu_resp_exception;

  logic                      mem_r_req_valid;
  logic                      mem_r_req_ready;
  logic [ADDR_WIDTH-1:0]     mem_r_req_addr;
  logic                      mem_r_resp_valid;
  logic [LINE_WIDTH-1:0]     mem_r_resp_rdata;

  logic                      mem_w_req_valid;
  logic                      mem_w_req_ready;
  logic [ADDR_WIDTH-1:0]     mem_w_req_addr;
  logic [LINE_WIDTH-1:0]     mem_w_req_data;
  logic [LINE_WIDTH/8-1:0]   mem_w_req_wmask;
  logic                      mem_w_resp_valid;

  modport slave (
    input  cpu_req_valid, cpu_req_addr, cpu_req_write, cpu_req_wdata, cpu_req_wmask,
    input  mem_r_req_ready, mem_r_resp_valid, mem_r_resp_rdata,
    input  mem_w_req_ready, mem_w_resp_valid,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit, cpu_resp_exception,
    output mem_r_req_valid, mem_r_req_addr,
    output mem_w_req_valid, mem_w_req_addr, mem_w_req_data, mem_w_req_wmask
  );

  modport master (
    output cpu_req_valid, cpu_req_addr, cpu_req_write, cpu_req_wdata, cpu_req_wmask,
    output mem_r_req_ready, mem_r_resp_valid, mem_r_resp_rdata,
    output mem_w_req_ready, mem_w_resp_valid,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit, cpu_resp_exception,
    input  mem_r_req_valid, mem_r_req_addr,
    input  mem_w_req_valid, mem_w_req_addr, mem_w_req_data, mem_w_req_wmask
  );
endinterface

// File: rtl/l1_dcache_sa.sv
// Set-associative write-back, write-allocate L1 data cache with round-robin replacement.
// Define DCACHE_PERF_CNT_EN to add the perf_hits / perf_misses counter outputs.
module l1_dcache_sa #(
  parameter int ADDR_WIDTH = 32,
  parameter int CPU_WIDTH  = 32,
  parameter int LINE_WIDTH = 128,
  parameter int SETS       = 4,
  parameter int WAYS       = 2
) (
  input  logic               clk,
  input  logic               rstn,
  l1_dcache_sa_if.slave      bus
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]        perf_hits,
  output logic [31:0]        perf_misses
`endif
);

  localparam int OFFSET    = $clog2(LINE_WIDTH/8);
  localparam int INDEX     = $clog2(SETS);
  localparam int TAG       = ADDR_WIDTH - INDEX - OFFSET;
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WORDS     = LINE_WIDTH / CPU_WIDTH;
  localparam int WORD_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CPU_BYTES = CPU_WIDTH / 8;
  localparam int BYTE_SH   = $clog2(CPU_BYTES);
  localparam int BIT_SH    = $clog2(CPU_WIDTH);

  typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT} state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]  req_addr_q;
  logic                   req_write_q;
  logic [CPU_WIDTH-1:0]   req_wdata_q;
  logic [CPU_BYTES-1:0]   req_wmask_q;
  logic                   filled_q;
  logic [WAY_W-1:0]       victim_q;

  logic                   valid_q [SETS][WAYS];
  logic                   dirty_q [SETS][WAYS];
  logic [TAG-1:0]         tag_q   [SETS][WAYS];
  logic [LINE_WIDTH-1:0]  data_q  [SETS][WAYS];
  logic [WAY_W-1:0]       rr_q    [SETS];

  logic [INDEX-1:0]          set_idx;
  logic [TAG-1:0]            req_tag;
  logic                      misaligned;
  logic [WORD_W-1:0]         word_idx;
  logic [WORD_W+BIT_SH-1:0]  word_lsb;
  logic                      hit;
  logic [WAY_W-1:0]          hit_way;
  logic                      inv_found;
  logic [WAY_W-1:0]          victim_way;
  logic [LINE_WIDTH-1:0]     hit_line;
  logic [LINE_WIDTH-1:0]     store_line;
  logic [CPU_WIDTH-1:0]      hit_word;
  logic                      lookup_hit;
  logic                      do_store;
  logic                      do_fill;

  assign set_idx    = req_addr_q[OFFSET +: INDEX];
  assign req_tag    = req_addr_q[ADDR_WIDTH-1 -: TAG];
  assign misaligned = |req_addr_q[1:0];
  assign word_idx   = (WORDS > 1) ? req_addr_q[BYTE_SH +: WORD_W] : '0;
  assign word_lsb   = {word_idx, {BIT_SH{1'b0}}};
  assign lookup_hit = (state_q == LOOKUP) && !misaligned && hit;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Descending scan so the lowest-index invalid way is the one that sticks.
  always_comb begin
    inv_found  = 1'b0;
    victim_way = rr_q[set_idx];
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (!valid_q[set_idx][w-1]) begin
        inv_found  = 1'b1;
        victim_way = WAY_W'(w-1);
      end
    end
  end

  always_comb begin
    hit_line   = data_q[set_idx][hit_way];
    hit_word   = hit_line[word_lsb +: CPU_WIDTH];
    store_line = hit_line;
    for (int unsigned b = 0; b < CPU_BYTES; b++) begin
      if (req_wmask_q[b]) begin
        store_line[int'(word_lsb) + 8*int'(b) +: 8] = req_wdata_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every output defaults to zero and is only driven while out of reset.
  always_comb begin
    state_d                = state_q;
    bus.cpu_req_ready      = 1'b0;
    bus.cpu_resp_valid     = 1'b0;
    bus.cpu_resp_rdata     = '0;
    bus.cpu_resp_hit       = 1'b0;
    bus.cpu_resp_exception = 1'b0;
    bus.mem_r_req_valid    = 1'b0;
    bus.mem_r_req_addr     = '0;
    bus.mem_w_req_valid    = 1'b0;
    bus.mem_w_req_addr     = '0;
    bus.mem_w_req_data     = '0;
    bus.mem_w_req_wmask    = '0;
    do_store               = 1'b0;
    do_fill                = 1'b0;
    if (rstn) begin
      case (state_q)
        IDLE: begin
          bus.cpu_req_ready = 1'b1;
          if (bus.cpu_req_valid) state_d = LOOKUP;
        end
        LOOKUP: begin
          if (misaligned) begin
            bus.cpu_resp_valid     = 1'b1;
            bus.cpu_resp_exception = 1'b1;
            state_d                = IDLE;
          end else if (hit) begin
            bus.cpu_resp_valid = 1'b1;
            bus.cpu_resp_rdata = hit_word;
            bus.cpu_resp_hit   = !filled_q;
            do_store           = req_write_q;
            state_d            = IDLE;
          end else if (valid_q[set_idx][victim_way] && dirty_q[set_idx][victim_way]) begin
            state_d = WB_REQ;
          end else begin
            state_d = RF_REQ;
          end
        end
        WB_REQ: begin
          bus.mem_w_req_valid = 1'b1;
          bus.mem_w_req_addr  = {tag_q[set_idx][victim_q], set_idx, {OFFSET{1'b0}}};
          bus.mem_w_req_data  = data_q[set_idx][victim_q];
          bus.mem_w_req_wmask = '1;
          if (bus.mem_w_req_ready) state_d = WB_WAIT;
        end
        WB_WAIT: begin
          if (bus.mem_w_resp_valid) state_d = RF_REQ;
        end
        RF_REQ: begin
          bus.mem_r_req_valid = 1'b1;
          bus.mem_r_req_addr  = {req_addr_q[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
          if (bus.mem_r_req_ready) state_d = RF_WAIT;
        end
        RF_WAIT: begin
          if (bus.mem_r_resp_valid) begin
            do_fill = 1'b1;
            state_d = LOOKUP;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      filled_q <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
        end
      end
    end else begin
      if ((state_q == IDLE) && bus.cpu_req_valid) begin
        req_addr_q  <= bus.cpu_req_addr;
        req_write_q <= bus.cpu_req_write;
        req_wdata_q <= bus.cpu_req_wdata;
        req_wmask_q <= bus.cpu_req_wmask;
        filled_q    <= 1'b0;
      end
      if ((state_q == LOOKUP) && !misaligned && !hit) begin
        victim_q <= victim_way;
      end
      if (do_store) begin
        data_q[set_idx][hit_way]  <= store_line;
        dirty_q[set_idx][hit_way] <= 1'b1;
      end
      if (do_fill) begin
        data_q[set_idx][victim_q]  <= bus.mem_r_resp_rdata;
        tag_q[set_idx][victim_q]   <= req_tag;
        valid_q[set_idx][victim_q] <= 1'b1;
        dirty_q[set_idx][victim_q] <= 1'b0;
        rr_q[set_idx]              <= (rr_q[set_idx] == WAY_W'(WAYS-1)) ? '0 : rr_q[set_idx] + 1'b1;
        filled_q                   <= 1'b1;
      end
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // A response after a refill is a miss; the one straight out of the first lookup is a hit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else if (lookup_hit) begin
      if (filled_q) perf_misses <= perf_misses + 1'b1;
      else          perf_hits   <= perf_hits + 1'b1;
    end
  end
`endif

endmodule

// File: doc/l1_dcache_sa.md
L1_DCACHE_SA -- requirements
Module: l1_dcache_sa

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter CPU_WIDTH, default 32, CPU data word width.
REQ-003 SHALL have parameter LINE_WIDTH, default 128, cache line and memory beat width.
REQ-004 SHALL have parameter SETS, default 4, number of sets (power of two).
REQ-005 SHALL have parameter WAYS, default 2, associativity (power of two, >=1).
REQ-006 SHALL derive OFFSET=log2(LINE_WIDTH/8), INDEX=log2(SETS), TAG=ADDR_WIDTH-INDEX-OFFSET.
REQ-007 SHALL have ports: clk in 1, clock; rstn in 1, reset, synchronous, active-low.
REQ-008 SHALL have ports: cpu_req_valid in 1; cpu_req_ready out 1; cpu_req_addr in ADDR_WIDTH; cpu_req_write in 1; cpu_req_wdata in CPU_WIDTH; cpu_req_wmask in CPU_WIDTH/8.
REQ-009 SHALL have ports: cpu_resp_valid out 1; cpu_resp_rdata out CPU_WIDTH; cpu_resp_hit out 1, no memory access was needed; cpu_resp_exception out 1, misaligned request.
REQ-010 SHALL have ports: mem_r_req_valid out 1; mem_r_req_ready in 1; mem_r_req_addr out ADDR_WIDTH; mem_r_resp_valid in 1; mem_r_resp_rdata in LINE_WIDTH.
REQ-011 SHALL have ports: mem_w_req_valid out 1; mem_w_req_ready in 1; mem_w_req_addr out ADDR_WIDTH; mem_w_req_data out LINE_WIDTH; mem_w_req_wmask out LINE_WIDTH/8; mem_w_resp_valid in 1.

Function
REQ-012 SHALL implement a WAYS-way set-associative, write-back, write-allocate cache with per-line valid, dirty and tag.
REQ-013 SHALL use FSM states IDLE, LOOKUP, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT.
REQ-014 SHALL assert cpu_req_ready only in IDLE; a request is accepted on valid&ready and registered, and the FSM moves to LOOKUP.
REQ-015 SHALL, in LOOKUP on a hit, pulse cpu_resp_valid for one cycle with cpu_resp_hit=1 and return to IDLE; hit latency is exactly 1 cycle after acceptance.
REQ-016 SHALL, on a store hit, update only the bytes enabled by wmask in the selected word and set dirty; cpu_resp_rdata then returns the pre-store word.
REQ-017 SHALL select the victim on a miss as the lowest-index invalid way; if none is invalid, the per-set round-robin pointer, which increments on each fill and wraps WAYS-1 to 0.
REQ-018 SHALL, on a miss with a dirty victim, go to WB_REQ, hold mem_w_req_valid with the victim address (tag,index,0), line data and all-ones wmask until mem_w_req_ready, then wait in WB_WAIT for mem_w_resp_valid.
REQ-019 SHALL, on a miss with a clean victim or after write-back, go to RF_REQ, hold mem_r_req_valid with the line-aligned address until mem_r_req_ready, then wait in RF_WAIT for mem_r_resp_valid.
REQ-020 SHALL, on mem_r_resp_valid, install the line (valid=1, dirty=0, new tag) and re-enter LOOKUP, which then hits and responds with cpu_resp_hit=0.
REQ-021 SHALL flag cpu_req_addr[1:0]!=0 as misaligned: response in LOOKUP with exception=1, rdata=0, hit=0, no array or memory change.
REQ-022 SHALL keep all mem request outputs stable while valid and not ready.
REQ-023 SHALL ignore mem_*_resp_valid outside the corresponding WAIT state.

Reset
REQ-024 SHALL, with rstn low at a clk edge, clear all valid, dirty and round-robin bits and enter IDLE, from any state including mid-write-back or mid-refill.
REQ-025 SHALL drive all outputs to 0 during reset, except cpu_req_ready, which is 1 in the first cycle after reset release.

Configuration
REQ-026 SHALL, when DCACHE_PERF_CNT_EN is defined, add outputs perf_hits and perf_misses (32 bits each), reset to 0, incremented once per hit or miss response and wrapping at 2^32-1 to 0.
REQ-027 SHALL, without DCACHE_PERF_CNT_EN, have no counter ports or logic, with all other behaviour identical.

Verification
REQ-028 Cold read 0x40, refill line 0x44444444_33333333_22222222_11111111 -> mem_r_req_addr=0x40, rdata=0x11111111, hit=0; a repeated read responds 1 cycle later with hit=1 and no mem traffic.
REQ-029 Store 0xAABBCCDD, wmask 4'b0011, to a cached word holding 0x11223344 -> a following read returns 0x1122CCDD and the line is dirty.
REQ-030 Fill set 0 with 0x000 and 0x040, store to 0x000, then read 0x080 -> write-back at 0x000 with all-ones wmask before refill at 0x080.
REQ-031 Read 0x102 -> exception=1 one cycle after acceptance, no mem_*_valid.
REQ-032 Assert rstn low during RF_WAIT -> IDLE with cpu_req_ready=1 after release, and a re-read of the same address misses.
REQ-033 With DCACHE_PERF_CNT_EN defined, 3 hits and 2 misses -> perf_hits=3, perf_misses=2.
